// File: rtl/gpu_op_sequencer_pkg.sv
// Shared definitions for the SLC3 GPU op sequencer.
//   state_e    : sequencer FSM states
//   gpu_op_e   : decoded GPU operation
//   rgb332_t   : RGB332 pixel, {R[2:0], G[2:0], B[1:0]}
//   decode_op(): maps a raw 16-bit IR onto gpu_op_e
package gpu_op_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ST_WR,
    ST_RD,
    ST_VS,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_WPIX,
    OP_GRSC,
    OP_INVR,
    OP_BRTN,
    OP_PUB,
    OP_ILLEGAL
  } gpu_op_e;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // WPIX carries its pixel in [7:0]; only the high byte identifies it.
  localparam logic [7:0]  WPIX_HI   = 8'h2F;
  localparam logic [15:0] GRSC_IR   = 16'hE000;
  localparam logic [15:0] PUB_IR    = 16'hE020;
  localparam logic [15:0] INVR_IR   = 16'hE800;
  // BRTN carries a 3-bit brightness offset in [2:0].
  localparam logic [15:0] BRTN_MASK = 16'hFFF8;
  localparam logic [15:0] BRTN_VAL  = 16'h3000;

  function automatic gpu_op_e decode_op(input logic [15:0] ir);
    gpu_op_e op;
    if (ir[15:8] == WPIX_HI)                op = OP_WPIX;
    else if (ir == GRSC_IR)                 op = OP_GRSC;
    else if (ir == PUB_IR)                  op = OP_PUB;
    else if (ir == INVR_IR)                 op = OP_INVR;
    else if ((ir & BRTN_MASK) == BRTN_VAL)  op = OP_BRTN;
    else                                    op = OP_ILLEGAL;
    return op;
  endfunction

endpackage

// File: rtl/pix_xform.sv
// Combinational per-pixel transform used by the whole-frame pass ops.
//   op      in  : decoded operation (GRSC, INVR, BRTN transform; others pass through)
//   off     in  : BRTN brightness offset
//   pix_in  in  : RGB332 pixel read from the back buffer
//   pix_out out : RGB332 pixel to write back
module pix_xform
  import gpu_op_sequencer_pkg::*;
(
  input  gpu_op_e    op,
  input  logic [2:0] off,
  input  logic [7:0] pix_in,
  output logic [7:0] pix_out
);

  rgb332_t    p;
  rgb332_t    q;
  logic [4:0] lum_sum;
  logic [2:0] y;

  function automatic logic [2:0] sat_add3(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[3] ? 3'd7 : s[2:0];
  endfunction

  function automatic logic [1:0] sat_add2(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[2] ? 2'd3 : s[1:0];
  endfunction

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    p = rgb332_t'(pix_in);
    // Luma weights R:G:B = 1:2:1 with B widened to 3 bits by replicating its MSB.
    lum_sum = {2'b00, p.r} + {1'b0, p.g, 1'b0} + {2'b00, p.b, p.b[1]};
    y       = 3'(lum_sum >> 2);
    q       = p;
    unique case (op)
      OP_INVR: q = ~p;
      OP_BRTN: begin
        q.r = sat_add3(p.r, off);
        q.g = sat_add3(p.g, off);
        q.b = sat_add2(p.b, off[1:0]);
      end
      OP_GRSC: begin
        q.r = y;
        q.g = y;
        q.b = y[2:1];
      end
      default: q = p;
    endcase
    pix_out = q;
  end

endmodule

// File: rtl/gpu_op_sequencer.sv
// Sequences SLC3 GPU instructions against a double-buffered RGB332 pixel SRAM.
//   Clk, Reset_n             : clock, asynchronous active-low reset
//   instr_valid/instr/ready  : instruction handshake from the CPU control FSM
//   done, illegal, busy      : completion pulse, bad-encoding pulse, in-progress flag
//   vsync, front_sel         : vertical-blank pulse, buffer currently scanned out
//   mem_addr/rd/we/wdata     : pixel SRAM port, addr = {buffer, index}
//   mem_rdata                : SRAM read data, valid the cycle after mem_rd
// All pixel traffic targets the back buffer {~front_sel, index}. WPIX writes one
// pixel at the cursor; GRSC/INVR/BRTN read-modify-write the whole back buffer;
// PUB swaps buffers on the next vsync.
module gpu_op_sequencer
  import gpu_op_sequencer_pkg::*;
#(
  parameter int IDX_W = 12
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic             done,
  output logic             illegal,
  output logic             busy,
  input  logic             vsync,
  output logic             front_sel,
  output logic [IDX_W:0]   mem_addr,
  output logic             mem_rd,
  output logic             mem_we,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata
);

  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  state_e           state;
  state_e           state_nxt;
  gpu_op_e          op_in;
  gpu_op_e          op_q;
  logic [7:0]       data_q;     // WPIX pixel, or BRTN offset in [2:0]
  logic [IDX_W-1:0] idx;        // pass position
  logic [IDX_W-1:0] cursor;     // WPIX position, untouched by passes and PUB
  logic [7:0]       xform_out;
  logic             accept;

  assign op_in  = decode_op(instr);
  assign accept = instr_valid && (state == IDLE);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (op_in)
            OP_WPIX:                    state_nxt = ST_WR;
            OP_GRSC, OP_INVR, OP_BRTN:  state_nxt = ST_RD;
            OP_PUB:                     state_nxt = ST_VS;
            default:                    state_nxt = ST_DONE;
          endcase
        end
      end
      ST_RD:   state_nxt = ST_WR;
      ST_WR: begin
        if (op_q == OP_WPIX || idx == LAST_IDX) state_nxt = ST_DONE;
        else                                    state_nxt = ST_RD;
      end
      // vsync is only observed from ST_VS, so one arriving while the PUB is
      // still being accepted is not mistaken for the swap point.
      ST_VS:   if (vsync) state_nxt = ST_DONE;
      ST_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    illegal     = 1'b0;
    mem_rd      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    unique case (state)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      ST_RD: begin
        mem_rd   = 1'b1;
        mem_addr = {~front_sel, idx};
      end
      ST_WR: begin
        mem_we = 1'b1;
        if (op_q == OP_WPIX) begin
          mem_addr  = {~front_sel, cursor};
          mem_wdata = data_q;
        end else begin
          // Same address as the preceding ST_RD; mem_rdata holds that pixel now.
          mem_addr  = {~front_sel, idx};
          mem_wdata = xform_out;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        illegal = (op_q == OP_ILLEGAL);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      op_q      <= OP_WPIX;
      data_q    <= '0;
      idx       <= '0;
      cursor    <= '0;
      front_sel <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= op_in;
        data_q <= instr[7:0];
        idx    <= '0;
      end
      if (state == ST_WR) begin
        if (op_q == OP_WPIX) cursor <= cursor + 1'b1;
        else                 idx    <= idx + 1'b1;
      end
      if (state == ST_VS && vsync) front_sel <= ~front_sel;
    end
  end

  pix_xform u_pix_xform (
    .op      (op_q),
    .off     (data_q[2:0]),
    .pix_in  (mem_rdata),
    .pix_out (xform_out)
  );

endmodule

// File: tb/tb_gpu_op_sequencer.sv
// Directed self-checking bench for gpu_op_sequencer with a behavioural
// synchronous-read pixel SRAM.
module tb_gpu_op_sequencer;

  localparam int IDX_W    = 12;
  localparam int NPIX     = 1 << IDX_W;
  localparam int PASS_LAT = 2 * NPIX + 1;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             instr_valid;
  logic [15:0]      instr;
  logic             instr_ready;
  logic             done;
  logic             illegal;
  logic             busy;
  logic             vsync;
  logic             front_sel;
  logic [IDX_W:0]   mem_addr;
  logic             mem_rd;
  logic             mem_we;
  logic [7:0]       mem_wdata;
  logic [7:0]       mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  gpu_op_sequencer #(.IDX_W(IDX_W)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .done        (done),
    .illegal     (illegal),
    .busy        (busy),
    .vsync       (vsync),
    .front_sel   (front_sel),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // SRAM model plus strobe bookkeeping. Preloads are requested through pre_go
  // so that this block is the only writer of mem.
  logic [7:0]     mem [0:2*NPIX-1];
  logic           pre_go = 1'b0;
  logic           pre_bank = 1'b0;
  logic [7:0]     pre_a = 8'h00;
  logic [7:0]     pre_b = 8'h00;
  int             n_rd = 0, n_we = 0, n_overlap = 0, n_badseq = 0, n_done = 0;
  logic           prev_rd = 1'b0;
  logic [IDX_W:0] prev_addr = '0;

  always @(posedge Clk) begin
    if (pre_go)
      for (int i = 0; i < NPIX; i++) mem[{pre_bank, IDX_W'(i)}] <= i[0] ? pre_b : pre_a;
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      n_we <= n_we + 1;
      if (!(prev_rd && prev_addr == mem_addr)) n_badseq <= n_badseq + 1;
    end
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      n_rd <= n_rd + 1;
    end
    if (mem_rd && mem_we) n_overlap <= n_overlap + 1;
    if (done) n_done <= n_done + 1;
    prev_rd   <= mem_rd;
    prev_addr <= mem_addr;
  end

  task automatic preload(input logic bank, input logic [7:0] a, input logic [7:0] b);
    @(negedge Clk);
    pre_bank = bank; pre_a = a; pre_b = b; pre_go = 1'b1;
    @(negedge Clk);
    pre_go = 1'b0;
  endtask

  // Presents ir; returns at the negedge of the first cycle after acceptance.
  task automatic issue(input logic [15:0] ir, input logic vs_at_accept);
    int w = 0;
    @(negedge Clk);
    instr = ir; instr_valid = 1'b1; vsync = vs_at_accept;
    while (instr_ready !== 1'b1 && w < 20) begin @(negedge Clk); w++; end
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_%h instr_ready got=%b exp=1", ir, instr_ready);
    end
    @(negedge Clk);
    instr_valid = 1'b0; vsync = 1'b0;
  endtask

  // Counts cycles after acceptance until done; lat == budget means it never came.
  task automatic wait_done(input int budget, output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < budget) begin @(negedge Clk); lat++; end
  endtask

  task automatic test_reset;
    Reset_n = 1'b1; instr_valid = 1'b0; instr = 16'h0000; vsync = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
    checks++; if ({busy, done, illegal} !== 3'b000) begin errors++; $display("FAIL reset_status got=%b exp=000", {busy, done, illegal}); end
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL reset_front_sel got=%b exp=0", front_sel); end
    checks++; if ({mem_rd, mem_we, mem_addr, mem_wdata} !== '0) begin errors++;
      $display("FAIL reset_mem got rd=%b we=%b addr=%h wdata=%h exp all 0", mem_rd, mem_we, mem_addr, mem_wdata); end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_wpix;
    int lat;
    for (int k = 0; k < 3; k++) begin
      issue(16'h2FE0, 1'b0);
      checks++;
      if ({busy, mem_we, mem_rd} !== 3'b110 || mem_addr !== 13'h1000 + 13'(k) || mem_wdata !== 8'hE0) begin
        errors++;
        $display("FAIL wpix%0d_write got busy=%b we=%b rd=%b addr=%h data=%h exp 1/1/0 addr=%h data=e0",
                 k, busy, mem_we, mem_rd, mem_addr, mem_wdata, 13'h1000 + 13'(k));
      end
      wait_done(10, lat);
      checks++; if (lat != 2 || illegal !== 1'b0) begin errors++;
        $display("FAIL wpix%0d_done latency got=%0d exp=2 illegal=%b", k, lat, illegal); end
    end
    checks++;
    if ({mem[13'h1000], mem[13'h1001], mem[13'h1002]} !== 24'hE0E0E0) begin
      errors++;
      $display("FAIL wpix_mem got=%h %h %h exp=e0 e0 e0", mem[13'h1000], mem[13'h1001], mem[13'h1002]);
    end
  endtask

  // Whole-frame pass on bank 1 (front_sel is 0 here): even indices hold pa, odd hold pb.
  task automatic run_pass(input string name, input logic [15:0] ir,
                          input logic [7:0] pa, input logic [7:0] pb,
                          input logic [7:0] ea, input logic [7:0] eb);
    int lat, bad, first, rd0, we0, ov0, bs0;
    logic [7:0] exp_v;
    preload(1'b1, pa, pb);
    rd0 = n_rd; we0 = n_we; ov0 = n_overlap; bs0 = n_badseq;
    issue(ir, 1'b0);
    checks++;
    if ({mem_rd, mem_we} !== 2'b10 || mem_addr !== 13'h1000) begin
      errors++;
      $display("FAIL %s_first_read got rd=%b we=%b addr=%h exp 1/0 addr=1000", name, mem_rd, mem_we, mem_addr);
    end
    wait_done(PASS_LAT + 100, lat);
    checks++; if (lat != PASS_LAT) begin errors++;
      $display("FAIL %s_latency got=%0d exp=%0d", name, lat, PASS_LAT); end
    bad = 0; first = 0;
    for (int i = 0; i < NPIX; i++) begin
      exp_v = i[0] ? eb : ea;
      if (mem[NPIX + i] !== exp_v) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_data %0d words wrong, idx %0d got=%h exp=%h", name, bad, first,
               mem[NPIX + first], first[0] ? eb : ea);
    end
    checks++;
    if (n_rd - rd0 != NPIX || n_we - we0 != NPIX || n_overlap != ov0 || n_badseq != bs0) begin
      errors++;
      $display("FAIL %s_strobes got rd=%0d we=%0d overlap=%0d unpaired=%0d exp %0d/%0d/0/0", name,
               n_rd - rd0, n_we - we0, n_overlap - ov0, n_badseq - bs0, NPIX, NPIX);
    end
    @(negedge Clk);
    checks++; if ({done, instr_ready} !== 2'b01) begin errors++;
      $display("FAIL %s_after_done got done=%b ready=%b exp 0/1", name, done, instr_ready); end
  endtask

  task automatic test_invr;
    run_pass("invr", 16'hE800, 8'h1C, 8'h1C, 8'hE3, 8'hE3);
  endtask

  task automatic test_brtn;
    // 62 = R3 G0 B2 -> R7 G5 B3 = f7 ; 00 -> R5 G5 B1 = b5
    run_pass("brtn", 16'h3005, 8'h62, 8'h00, 8'hF7, 8'hB5);
  endtask

  task automatic test_grsc;
    // ff: (7+14+7)>>2 = 7 -> ff ; e0: (7+0+0)>>2 = 1 -> {001,001,00} = 24
    run_pass("grsc", 16'hE000, 8'hFF, 8'hE0, 8'hFF, 8'h24);
  endtask

  task automatic test_pub;
    int early = 0, rd0, we0;
    rd0 = n_rd; we0 = n_we;
    // vsync pulsed during the acceptance cycle must not cause the swap.
    issue(16'hE020, 1'b1);
    checks++; if ({busy, front_sel} !== 2'b10) begin errors++;
      $display("FAIL pub_wait got busy=%b front_sel=%b exp 1/0", busy, front_sel); end
    for (int c = 2; c <= 10; c++) begin
      @(negedge Clk);
      if (done !== 1'b0 || front_sel !== 1'b0) early++;
    end
    vsync = 1'b1;
    checks++; if (early != 0) begin errors++;
      $display("FAIL pub_early_swap got=%0d early cycles exp=0", early); end
    @(negedge Clk);
    vsync = 1'b0;
    checks++; if ({front_sel, done, illegal} !== 3'b110) begin errors++;
      $display("FAIL pub_swap got front_sel=%b done=%b illegal=%b exp 1/1/0", front_sel, done, illegal); end
    checks++; if (n_rd != rd0 || n_we != we0) begin errors++;
      $display("FAIL pub_strobes got rd=%0d we=%0d exp 0/0", n_rd - rd0, n_we - we0); end
  endtask

  // Cursor sits at 3 after three WPIX; passes and PUB leave it alone; back bank is now 0.
  task automatic test_wpix_after_pub;
    int lat;
    issue(16'h2F5A, 1'b0);
    checks++; if (mem_addr !== 13'h0003 || mem_we !== 1'b1) begin errors++;
      $display("FAIL wpix_pub_addr got addr=%h we=%b exp addr=0003 we=1", mem_addr, mem_we); end
    wait_done(10, lat);
    @(negedge Clk);
    checks++; if (mem[13'h0003] !== 8'h5A || lat != 2) begin errors++;
      $display("FAIL wpix_pub_mem got data=%h lat=%0d exp 5a/2", mem[13'h0003], lat); end
  endtask

  task automatic test_illegal;
    logic [15:0] vec [2] = '{16'hE001, 16'h3008};
    int rd0, we0;
    for (int k = 0; k < 2; k++) begin
      rd0 = n_rd; we0 = n_we;
      issue(vec[k], 1'b0);
      checks++; if ({done, illegal, mem_rd, mem_we} !== 4'b1100) begin errors++;
        $display("FAIL illegal_%h got done=%b illegal=%b rd=%b we=%b exp 1/1/0/0",
                 vec[k], done, illegal, mem_rd, mem_we); end
      @(negedge Clk);
      checks++; if ({done, illegal, instr_ready} !== 3'b001 || n_rd != rd0 || n_we != we0) begin errors++;
        $display("FAIL illegal_%h_after got done=%b illegal=%b ready=%b rd=%0d we=%0d exp 0/0/1/0/0",
                 vec[k], done, illegal, instr_ready, n_rd - rd0, n_we - we0); end
    end
  endtask

  task automatic test_reset_mid_pass;
    int d0;
    preload(1'b0, 8'h1C, 8'h1C);   // front_sel is 1, so bank 0 is the back buffer
    issue(16'hE800, 1'b0);
    repeat (99) @(negedge Clk);
    d0 = n_done;
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({instr_ready, busy, done, mem_rd, mem_we, front_sel} !== 6'b100000) begin
      errors++;
      $display("FAIL midreset_outputs got ready=%b busy=%b done=%b rd=%b we=%b front_sel=%b exp 1/0/0/0/0/0",
               instr_ready, busy, done, mem_rd, mem_we, front_sel);
    end
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (20) @(negedge Clk);
    checks++; if (n_done != d0 || instr_ready !== 1'b1) begin errors++;
      $display("FAIL midreset_no_done got done_pulses=%0d ready=%b exp 0/1", n_done - d0, instr_ready); end
    checks++; if (mem[0] !== 8'hE3 || mem[NPIX - 1] !== 8'h1C) begin errors++;
      $display("FAIL midreset_partial got first=%h last=%h exp e3/1c", mem[0], mem[NPIX - 1]); end
  endtask

  // Cursor restarts at 0 after reset and wraps from 2**IDX_W-1 back to 0.
  task automatic test_cursor_wrap;
    int lat, bad = 0;
    issue(16'h2F11, 1'b0);
    checks++; if (mem_addr !== 13'h1000) begin errors++;
      $display("FAIL cursor_after_reset got addr=%h exp=1000", mem_addr); end
    wait_done(10, lat);
    for (int k = 1; k < NPIX - 1; k++) begin
      issue(16'h2F11, 1'b0);
      wait_done(10, lat);
      if (lat != 2) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL cursor_fill got=%0d slow writes exp=0", bad); end
    issue(16'h2FA5, 1'b0);
    checks++; if (mem_addr !== 13'h1FFF) begin errors++;
      $display("FAIL cursor_last got addr=%h exp=1fff", mem_addr); end
    wait_done(10, lat);
    issue(16'h2F3C, 1'b0);
    checks++; if (mem_addr !== 13'h1000) begin errors++;
      $display("FAIL cursor_wrap got addr=%h exp=1000", mem_addr); end
    wait_done(10, lat);
    @(negedge Clk);
    checks++;
    if ({mem[13'h1FFF], mem[13'h1000], mem[13'h1001]} !== 24'hA53C11) begin
      errors++;
      $display("FAIL cursor_mem got=%h %h %h exp=a5 3c 11", mem[13'h1FFF], mem[13'h1000], mem[13'h1001]);
    end
  endtask

  initial begin
    test_reset();
    test_wpix();
    test_invr();
    test_brtn();
    test_grsc();
    test_pub();
    test_wpix_after_pub();
    test_illegal();
    test_reset_mid_pass();
    test_cursor_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
